occupancy_counter_p: RTL and testbench

- Parametrised entry/exit occupancy counter; successor to the fixed 3-bit, 7-slot counter.
- Counts rising edges on an entry sensor (up) and an exit sensor (down), saturating at 0 and CAPACITY.
- Flags full, almost-full and empty, and records overflow/underflow attempts in sticky error bits.
- Drives the lot/zone status logic and display decoders.

---
 rtl/occupancy_counter_p.sv | 107 ++++++++++
 tb/tb_occupancy_counter_p.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/occupancy_counter_p.sv
// Entry/exit occupancy counter: saturating up/down count from sensor rising edges, with status flags and sticky errors.
// Latency: an edge sampled on a clock updates c on that clock (1 cycle); 3 cycles with OCC_SYNC_EN defined. There is no backpressure.
module occupancy_counter_p #(
    parameter int WIDTH     = 4,
    parameter int CAPACITY  = 12,
    parameter int ALMOST_TH = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             z1,
    input  logic             z2,
    input  logic             err_clr,
    output logic [WIDTH-1:0] c,
    output logic             lleno,
    output logic             almost_full,
    output logic             empty,
    output logic             err_over,
    output logic             err_under
);

    if (CAPACITY > (2**WIDTH) - 1) begin : g_cap_chk
        $error("occupancy_counter_p: CAPACITY does not fit in WIDTH bits");
    end
    if (ALMOST_TH > CAPACITY) begin : g_th_chk
        $error("occupancy_counter_p: ALMOST_TH exceeds CAPACITY");
    end

    localparam logic [WIDTH-1:0] CAP_W = WIDTH'(CAPACITY);
    localparam logic [WIDTH-1:0] TH_W  = WIDTH'(ALMOST_TH);

    typedef enum logic [1:0] {
        S_EMPTY   = 2'd0,
        S_PARTIAL = 2'd1,
        S_FULL    = 2'd2
    } occ_state_e;

    logic [WIDTH-1:0] c_q, c_d;
    logic             z1_q, z2_q;
    logic             err_over_q, err_under_q;
    logic             z1_s, z2_s;
    logic             inc, dec, set_over, set_under;
    occ_state_e       state;

`ifdef OCC_SYNC_EN
    // Synchronizer flops reset high so a sensor held through reset never looks like an edge.
    logic [1:0] z1_sync_q, z2_sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            z1_sync_q <= 2'b11;
            z2_sync_q <= 2'b11;
        end else begin
            z1_sync_q <= {z1_sync_q[0], z1};
            z2_sync_q <= {z2_sync_q[0], z2};
        end
    end

    assign z1_s = z1_sync_q[1];
    assign z2_s = z2_sync_q[1];
`else
    assign z1_s = z1;
    assign z2_s = z2;
`endif

    always_comb begin
        inc       = z1_s & ~z1_q;
        dec       = z2_s & ~z2_q;
        state     = (c_q == '0)    ? S_EMPTY :
                    (c_q == CAP_W) ? S_FULL  : S_PARTIAL;
        c_d       = c_q;
        set_over  = 1'b0;
        set_under = 1'b0;
        // Simultaneous entry and exit cancel out, even at the limits.
        if (inc && !dec) begin
            if (state == S_FULL) set_over = 1'b1;
            else                 c_d = c_q + WIDTH'(1);
        end else if (dec && !inc) begin
            if (state == S_EMPTY) set_under = 1'b1;
            else                  c_d = c_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            c_q         <= '0;
            z1_q        <= 1'b1;
            z2_q        <= 1'b1;
            err_over_q  <= 1'b0;
            err_under_q <= 1'b0;
        end else begin
            c_q         <= c_d;
            z1_q        <= z1_s;
            z2_q        <= z2_s;
            // A new error event outranks a clear in the same cycle.
            err_over_q  <= set_over  | (err_over_q  & ~err_clr);
            err_under_q <= set_under | (err_under_q & ~err_clr);
        end
    end

    assign c           = c_q;
    assign lleno       = (c_q == CAP_W);
    assign almost_full = (c_q >= TH_W);
    assign empty       = (c_q == '0);
    assign err_over    = err_over_q;
    assign err_under   = err_under_q;

endmodule

// File: tb/tb_occupancy_counter_p.sv
// Directed bench for occupancy_counter_p with a per-cycle reference model of occupancy.
module tb_occupancy_counter_p;

    localparam int W   = 4;
    localparam int CAP = 12;
    localparam int TH  = 10;

    logic         clk;
    logic         reset, z1, z2, err_clr;
    logic [W-1:0] c;
    logic         lleno, almost_full, empty, err_over, err_under;

    int nchk, nerr;

    // Reference model state
    int cnt;
    bit m_eo, m_eu, pz1, pz2;

    occupancy_counter_p #(.WIDTH(W), .CAPACITY(CAP), .ALMOST_TH(TH)) dut (
        .clk(clk), .reset(reset), .z1(z1), .z2(z2), .err_clr(err_clr),
        .c(c), .lleno(lleno), .almost_full(almost_full), .empty(empty),
        .err_over(err_over), .err_under(err_under)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int got, input int exp);
        nchk++;
        if (got != exp) begin
            nerr++;
            $display("FAIL %s got=%0d exp=%0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_step();
        bit in_e, out_e;
        if (reset) begin
            cnt = 0; m_eo = 0; m_eu = 0; pz1 = 1; pz2 = 1;
        end else begin
            in_e  = z1 && !pz1;
            out_e = z2 && !pz2;
            if (err_clr) begin m_eo = 0; m_eu = 0; end
            if (in_e && !out_e) begin
                if (cnt == CAP) m_eo = 1; else cnt = cnt + 1;
            end else if (out_e && !in_e) begin
                if (cnt == 0) m_eu = 1; else cnt = cnt - 1;
            end
            pz1 = z1; pz2 = z2;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("model_c",      int'(c),           cnt);
        chk("model_lleno",  int'(lleno),       int'(cnt == CAP));
        chk("model_almost", int'(almost_full), int'(cnt >= TH));
        chk("model_empty",  int'(empty),       int'(cnt == 0));
        chk("model_eo",     int'(err_over),    int'(m_eo));
        chk("model_eu",     int'(err_under),   int'(m_eu));
    endtask

    task automatic pulse_z1();
        z1 = 1; tick(); z1 = 0; tick(); tick();
    endtask

    task automatic pulse_z2();
        z2 = 1; tick(); z2 = 0; tick(); tick();
    endtask

    task automatic do_reset();
        reset = 1; tick(); tick(); reset = 0; tick();
    endtask

    initial begin
        nchk = 0; nerr = 0;
        cnt = 0; m_eo = 0; m_eu = 0; pz1 = 1; pz2 = 1;
        reset = 1; z1 = 0; z2 = 0; err_clr = 0;
        do_reset();
        chk("rst_c", int'(c), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_errs", int'({err_over, err_under}), 0);

        // Count up to capacity
        for (int i = 1; i <= 12; i++) begin
            pulse_z1();
            if (i == 1)  chk("first_empty", int'(empty), 0);
            if (i == 9)  chk("almost_at9", int'(almost_full), 0);
            if (i == 10) chk("almost_at10", int'(almost_full), 1);
            if (i == 11) chk("lleno_at11", int'(lleno), 0);
        end
        chk("full_c", int'(c), 12);
        chk("full_lleno", int'(lleno), 1);

        // Overflow attempt, then clear
        pulse_z1();
        chk("ovf_c", int'(c), 12);
        chk("ovf_flag", int'(err_over), 1);
        err_clr = 1; tick(); err_clr = 0; tick();
        chk("clr_flag", int'(err_over), 0);
        chk("clr_c", int'(c), 12);

        // Simultaneous edges at capacity
        z1 = 1; z2 = 1; tick(); z1 = 0; z2 = 0; tick();
        chk("both_at12_c", int'(c), 12);
        chk("both_at12_err", int'({err_over, err_under}), 0);

        // Underflow from reset, sticky across a later entry
        do_reset();
        pulse_z2();
        chk("unf_c", int'(c), 0);
        chk("unf_flag", int'(err_under), 1);
        pulse_z1();
        chk("unf_then_in_c", int'(c), 1);
        chk("unf_sticky", int'(err_under), 1);

        // Simultaneous edges at zero
        do_reset();
        z1 = 1; z2 = 1; tick(); z1 = 0; z2 = 0; tick();
        chk("both_at0_c", int'(c), 0);
        chk("both_at0_err", int'({err_over, err_under}), 0);

        // Simultaneous edges mid-range
        for (int i = 0; i < 5; i++) pulse_z1();
        z1 = 1; z2 = 1; tick(); z1 = 0; z2 = 0; tick();
        chk("both_at5_c", int'(c), 5);
        chk("both_at5_err", int'({err_over, err_under}), 0);

        // Level held high counts once
        z1 = 1;
        for (int i = 0; i < 20; i++) tick();
        z1 = 0; tick();
        chk("held_c", int'(c), 6);

        // Sensor held through reset release does not count
        z1 = 1; reset = 1; tick(); tick(); reset = 0;
        tick(); tick(); tick();
        chk("held_rst_c", int'(c), 0);
        z1 = 0; tick();

        // Error set wins over simultaneous clear
        z2 = 1; err_clr = 1; tick(); z2 = 0; err_clr = 0; tick();
        chk("set_wins", int'(err_under), 1);

        // Reset mid-operation at c=7 with an edge and clear pending
        do_reset();
        for (int i = 0; i < 7; i++) pulse_z1();
        chk("pre_mid_c", int'(c), 7);
        z1 = 1; err_clr = 1; reset = 1; tick();
        reset = 0; z1 = 0; err_clr = 0;
        chk("mid_rst_c", int'(c), 0);
        chk("mid_rst_flags", int'({lleno, almost_full, empty, err_over, err_under}), 5'b00100);
        tick();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
